polyshift_mw_seq: RTL and testbench

//  Multi-word right-shift sequencer: shifts a word_count*word_width operand by 0..N*W-1 bits.
//  It time-shares one polyshift_r instance (RCR mode), producing one result word per cycle, LS word first.
//  It computes word offset, fill words and bit offset for each pass.
//  It sits between the ALU issue logic and the shifter datapath for double/quad-precision shifts.

---
 rtl/polyshift_mw_seq.sv | 178 +++++++++++++++++
 tb/tb_polyshift_mw_seq.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/polyshift_mw_seq.sv
// polyshift_mw_seq: multi-word right-shift sequencer built around one word-wide
// polyshift_r shifter used in RCR mode; emits one result word per cycle, LS word first.
`default_nettype none

module polyshift_r #(
    parameter int word_width = 8,
    localparam int BW = $clog2(word_width)
) (
    input  logic [word_width-1:0] D_IN,
    input  logic [word_width-2:0] C_IN,
    input  logic [BW-1:0]         SHIFT_SIZE,
    input  logic [1:0]            SHIFT_TYPE,
    output logic [word_width-1:0] D_OUT
);
    localparam int W = word_width;

    logic [2*W-2:0] rcr_ext;
    logic [2*W-1:0] ror_ext;

    always_comb begin
        rcr_ext = {C_IN, D_IN} >> SHIFT_SIZE;
        ror_ext = {D_IN, D_IN} >> SHIFT_SIZE;
        D_OUT   = '0;
        case (SHIFT_TYPE)
            2'd0:    D_OUT = D_IN >> SHIFT_SIZE;
            2'd1:    D_OUT = $signed(D_IN) >>> SHIFT_SIZE;
            2'd2:    D_OUT = rcr_ext[W-1:0];
            default: D_OUT = ror_ext[W-1:0];
        endcase
    end
endmodule

module polyshift_mw_seq #(
    parameter int word_width = 8,
    parameter int word_count = 4,
    localparam int TW = word_width * word_count,
    localparam int AW = $clog2(TW),
    localparam int BW = $clog2(word_width)
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  IN_VALID,
    output logic                  IN_READY,
    input  logic [TW-1:0]         D_IN,
    input  logic [word_width-2:0] C_IN,
    input  logic [AW-1:0]         SHIFT_AMT,
    input  logic [1:0]            SHIFT_TYPE,
    output logic                  OUT_VALID,
    input  logic                  OUT_READY,
    output logic [TW-1:0]         D_OUT,
    output logic                  BUSY
);
    localparam int W  = word_width;
    localparam int N  = word_count;
    localparam int IW = $clog2(N);
    localparam int SW = IW + 1;

    localparam logic [1:0] ST_LOGIC = 2'd0;
    localparam logic [1:0] ST_ARITH = 2'd1;
    localparam logic [1:0] ST_RCR   = 2'd2;
    localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [TW-1:0]   opnd_q, opnd_d;
    logic [W-2:0]    cin_q, cin_d;
    logic [AW-1:0]   amt_q, amt_d;
    logic [1:0]      type_q, type_d;
    logic [TW-1:0]   dout_q, dout_d;

    logic [SW-1:0]   src_lo_idx, src_hi_idx;
    logic [W-1:0]    src_lo, src_hi, shift_res;

    // Words beyond the operand (j >= N) come from the type-dependent fill.
    function automatic logic [W-1:0] src_word(
        input logic [SW-1:0] j,
        input logic [TW-1:0] opnd,
        input logic [W-2:0]  cin,
        input logic [1:0]    st
    );
        logic [W-1:0] w;
        w = '0;
        for (int i = 0; i < N; i++) begin
            if (j[IW-1:0] == IW'(i)) w = opnd[i*W +: W];
        end
        if (j[IW]) begin
            case (st)
                ST_LOGIC: w = '0;
                ST_ARITH: w = {W{opnd[TW-1]}};
                ST_RCR:   w = (j[IW-1:0] == '0) ? {1'b0, cin} : '0;
                default:  w = w;
            endcase
        end
        return w;
    endfunction

    always_comb begin
        src_lo_idx = {1'b0, idx_q} + {1'b0, amt_q[AW-1:BW]};
        src_hi_idx = src_lo_idx + SW'(1);
        src_lo     = src_word(src_lo_idx, opnd_q, cin_q, type_q);
        src_hi     = src_word(src_hi_idx, opnd_q, cin_q, type_q);
    end

    polyshift_r #(.word_width(W)) u_shift (
        .D_IN      (src_lo),
        .C_IN      (src_hi[W-2:0]),
        .SHIFT_SIZE(amt_q[BW-1:0]),
        .SHIFT_TYPE(ST_RCR),
        .D_OUT     (shift_res)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        opnd_d  = opnd_q;
        cin_d   = cin_q;
        amt_d   = amt_q;
        type_d  = type_q;
        dout_d  = dout_q;
        case (state_q)
            S_IDLE: begin
                if (IN_VALID) begin
                    opnd_d  = D_IN;
                    cin_d   = C_IN;
                    amt_d   = SHIFT_AMT;
                    type_d  = SHIFT_TYPE;
                    idx_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                for (int i = 0; i < N; i++) begin
                    if (idx_q == IW'(i)) dout_d[i*W +: W] = shift_res;
                end
                if (idx_q == IDX_LAST) begin
                    idx_d   = '0;
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            S_DONE: begin
                if (OUT_READY) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            opnd_q  <= '0;
            cin_q   <= '0;
            amt_q   <= '0;
            type_q  <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            opnd_q  <= opnd_d;
            cin_q   <= cin_d;
            amt_q   <= amt_d;
            type_q  <= type_d;
            dout_q  <= dout_d;
        end
    end

    assign IN_READY  = (state_q == S_IDLE);
    assign OUT_VALID = (state_q == S_DONE);
    assign BUSY      = (state_q == S_RUN);
    assign D_OUT     = dout_q;

endmodule

`default_nettype wire

// File: tb/tb_polyshift_mw_seq.sv
// tb_polyshift_mw_seq: directed-vector bench for polyshift_mw_seq (W=8, N=4).
`default_nettype none

module tb_polyshift_mw_seq;
    localparam logic [1:0] LOGIC = 2'd0, ARITH = 2'd1, RCR = 2'd2, ROR = 2'd3;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        IN_VALID = 1'b0;
    logic        IN_READY;
    logic [31:0] D_IN = '0;
    logic [6:0]  C_IN = '0;
    logic [4:0]  SHIFT_AMT = '0;
    logic [1:0]  SHIFT_TYPE = '0;
    logic        OUT_VALID;
    logic        OUT_READY = 1'b0;
    logic [31:0] D_OUT;
    logic        BUSY;

    int n_vec = 0;
    int n_bad = 0;

    polyshift_mw_seq #(.word_width(8), .word_count(4)) dut (
        .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .D_IN(D_IN), .C_IN(C_IN), .SHIFT_AMT(SHIFT_AMT), .SHIFT_TYPE(SHIFT_TYPE),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .D_OUT(D_OUT), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input logic [1:0] st, input logic [31:0] d,
                            input logic [6:0] c, input logic [4:0] amt);
        int guard;
        guard = 0;
        @(negedge CLK);
        while (!IN_READY && guard < 20) begin
            @(negedge CLK);
            guard++;
        end
        check("ready_wait", 32'(IN_READY), 32'd1);
        SHIFT_TYPE = st; D_IN = d; C_IN = c; SHIFT_AMT = amt;
        IN_VALID = 1'b1;
        @(posedge CLK);
        #1;
        IN_VALID = 1'b0;
    endtask

    task automatic finish_op(input string tag, input logic [31:0] exp);
        int cyc;
        cyc = 0;
        while (!OUT_VALID && cyc < 20) begin
            @(posedge CLK);
            #1;
            cyc++;
        end
        check({tag, "_lat"}, 32'(cyc), 32'd4);
        check(tag, D_OUT, exp);
        OUT_READY = 1'b1;
        @(posedge CLK);
        #1;
        OUT_READY = 1'b0;
        check({tag, "_rel"}, {30'd0, OUT_VALID, IN_READY}, 32'b01);
    endtask

    task automatic run_op(input string tag, input logic [1:0] st, input logic [31:0] d,
                          input logic [6:0] c, input logic [4:0] amt, input logic [31:0] exp);
        start_op(st, d, c, amt);
        finish_op(tag, exp);
    endtask

    initial begin
        logic [31:0] held;

        #12;
        check("rst_flags", {28'd0, IN_READY, OUT_VALID, BUSY, 1'b0}, 32'b1000);
        check("rst_dout", D_OUT, 32'h0);
        #3 RST_N = 1'b1;

        // T1 with a BUSY probe during the pass
        start_op(LOGIC, 32'h80FF_0001, 7'h00, 5'd4);
        check("t1_busy", {31'd0, BUSY}, 32'd1);
        finish_op("t1_logic4", 32'h080F_F000);

        run_op("t2_arith31", ARITH, 32'h8000_0000, 7'h00, 5'd31, 32'hFFFF_FFFF);
        run_op("t2_arith0",  ARITH, 32'h8000_0000, 7'h00, 5'd0,  32'h8000_0000);
        run_op("t3_ror12",   ROR,   32'h1234_5678, 7'h00, 5'd12, 32'h6781_2345);
        run_op("t3_ror8",    ROR,   32'h1234_5678, 7'h00, 5'd8,  32'h7812_3456);
        run_op("t4_rcr8",    RCR,   32'h0000_0000, 7'h55, 5'd8,  32'h5500_0000);
        run_op("t4_rcr1",    RCR,   32'h0000_0000, 7'h55, 5'd1,  32'h8000_0000);
        run_op("logic31",    LOGIC, 32'h8000_0000, 7'h00, 5'd31, 32'h0000_0001);
        run_op("logic17",    LOGIC, 32'h1234_5678, 7'h00, 5'd17, 32'h0000_091A);
        run_op("ror0",       ROR,   32'hDEAD_BEEF, 7'h00, 5'd0,  32'hDEAD_BEEF);
        run_op("rcr0",       RCR,   32'hCAFE_F00D, 7'h7F, 5'd0,  32'hCAFE_F00D);
        run_op("rcr4",       RCR,   32'h0000_00F0, 7'h03, 5'd4,  32'h3000_000F);
        run_op("arith4",     ARITH, 32'hF000_0000, 7'h00, 5'd4,  32'hFF00_0000);

        // T5: back-pressure in DONE with a competing request held high
        start_op(ROR, 32'h1234_5678, 7'h00, 5'd12);
        repeat (4) @(posedge CLK);
        #1;
        held = D_OUT;
        check("t5_done", held, 32'h6781_2345);
        SHIFT_TYPE = LOGIC; D_IN = 32'hFFFF_FFFF; SHIFT_AMT = 5'd1;
        IN_VALID = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge CLK);
            #1;
            check("t5_hold", {D_OUT[31:2], OUT_VALID, IN_READY}, {held[31:2], 2'b10});
        end
        OUT_READY = 1'b1;
        @(posedge CLK);
        #1;
        OUT_READY = 1'b0;
        IN_VALID = 1'b0;
        check("t5_release", {29'd0, OUT_VALID, IN_READY, BUSY}, 32'b010);
        check("t5_dout", D_OUT, 32'h6781_2345);

        // T6: asynchronous reset while idx==2
        start_op(LOGIC, 32'h80FF_0001, 7'h00, 5'd4);
        repeat (2) @(posedge CLK);
        #1;
        RST_N = 1'b0;
        #1;
        check("t6_flags", {29'd0, IN_READY, OUT_VALID, BUSY}, 32'b100);
        check("t6_dout", D_OUT, 32'h0);
        #2 RST_N = 1'b1;
        run_op("t6_after", LOGIC, 32'h80FF_0001, 7'h00, 5'd4, 32'h080F_F000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule

`default_nettype wire
